rom_lut_sequencer: RTL
======================

ROM_LUT_SEQUENCER -- requirements
Module: rom_lut_sequencer

Interface
REQ-001 SHALL have parameter ROM_ADDR_WIDTH, default 8, ROM address width.
REQ-002 SHALL have parameter ROM_DATA_WIDTH, default 8, ROM data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 SHALL have port in_clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port in_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_req  input  2  burst request, bit i = requester i.
REQ-007 SHALL have port in_addr  input  2*ROM_ADDR_WIDTH  start address; slice i = requester i.
REQ-008 SHALL have port in_len  input  2*LEN_WIDTH  burst length minus one; slice i = requester i.
REQ-009 SHALL have port out_ack  output  2  one-cycle grant acknowledge per requester.
REQ-010 SHALL have port out_rom_addr  output  ROM_ADDR_WIDTH  registered address to the ROM read port.
REQ-011 SHALL have port in_rom_data  input  ROM_DATA_WIDTH  ROM read data, valid one cycle after address.
REQ-012 SHALL have port out_data  output  ROM_DATA_WIDTH  returned word, direct from in_rom_data.
REQ-013 SHALL have port out_valid  output  2  out_data valid for requester i.
REQ-014 SHALL have port out_last  output  1  final word of burst, qualified by out_valid.
REQ-015 SHALL have port out_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN.
REQ-017 IDLE: in_req sampled in cycle T with any bit set SHALL latch winner's addr/len and enter READ; out_ack[winner]=1 in T+1 only.
REQ-018 READ: out_rom_addr SHALL equal start address in T+1, incrementing by one per cycle, wrapping 2**ROM_ADDR_WIDTH-1 -> 0.
REQ-019 READ SHALL issue exactly in_len+1 addresses, then enter DRAIN for one cycle, then IDLE.
REQ-020 Word k SHALL appear with out_valid[winner]=1 in cycle T+2+k; out_last=1 with word in_len only.
REQ-021 Throughput SHALL be one word per cycle within a burst; no gaps.
REQ-022 in_req, in_addr, in_len SHALL be ignored outside IDLE; a request still high on return to IDLE SHALL start a new burst.
REQ-023 in_len=0 SHALL produce a single word with out_valid and out_last in the same cycle.
REQ-024 out_valid SHALL be one-hot or zero; never both bits.
REQ-025 Idle-to-idle minimum burst occupancy SHALL be in_len+3 cycles (IDLE sample, READ, DRAIN).

Reset
REQ-026 in_rst high SHALL on the next edge force IDLE and all outputs 0, out_rom_addr 0, arbitration pointer to favour requester 0.
REQ-027 Reset mid-burst SHALL abandon the burst: no further out_valid, no out_last.

Configuration
REQ-028 With ROM_LUT_SEQ_RR_EN defined, simultaneous requests SHALL be granted round-robin: requester not granted last wins.
REQ-029 Without ROM_LUT_SEQ_RR_EN, requester 0 SHALL always win simultaneous requests.

Structure
REQ-030 Package rom_lut_seq_pkg SHALL hold the state enum and requester-count constant (2).
REQ-031 Arbitration SHALL be a sub-module rom_lut_seq_arb (request vector, update strobe, one-hot grant).

Verification
REQ-032 Reset, then req0 addr=0x10 len=3 -> ack0 at T+1, rom addr 0x10..0x13, valid0 T+2..T+5, last at T+5.
REQ-033 req1 addr=0xFE len=3 -> rom addr 0xFE,0xFF,0x00,0x01, four valid1 words, last on fourth.
REQ-034 req0 and req1 together, three times, RR_EN -> grants 0,1,0; without macro -> 0,0,0.
REQ-035 req0 len=0 -> one word, valid0 and last same cycle, busy low three cycles after sample.
REQ-036 in_rst asserted on third word of len=7 burst -> next cycle valid=0, last=0, busy=0, rom addr 0; new request afterwards served normally.

Source files
------------

// File: rtl/rom_lut_seq_pkg.sv
// ---------------------------------------------------------------------------
// rom_lut_seq_pkg
// Shared definitions for the ROM look-up-table burst sequencer.
//   state_t : sequencer FSM states (IDLE -> READ -> DRAIN -> IDLE)
//   N_REQ   : number of requesters served by the sequencer (fixed at 2)
// ---------------------------------------------------------------------------
package rom_lut_seq_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_lut_seq_arb.sv
// ---------------------------------------------------------------------------
// rom_lut_seq_arb
// Two-requester arbiter producing a one-hot grant.
// Configuration macro: ROM_LUT_SEQ_RR_EN
//   defined   : on a tie, the requester not granted last time wins
//   undefined : on a tie, requester 0 always wins
// Ports:
//   in_clk     clock
//   in_rst     synchronous active-high reset (favours requester 0)
//   in_req     request vector, bit i = requester i
//   in_update  strobe: the current grant is being taken, advance priority
//   out_grant  one-hot grant (zero when no request), combinational
// ---------------------------------------------------------------------------
module rom_lut_seq_arb
    import rom_lut_seq_pkg::*;
(
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [N_REQ-1:0] in_req,
    input  logic             in_update,
    output logic [N_REQ-1:0] out_grant
);

    // Index of the requester that wins a tie. One bit suffices for two requesters.
    logic r_favour;

    always_comb begin
        out_grant = '0;
        if (in_req[r_favour]) begin
            out_grant[r_favour] = 1'b1;
        end else if (in_req[~r_favour]) begin
            out_grant[~r_favour] = 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_favour <= 1'b0;
        end else if (in_update) begin
`ifdef ROM_LUT_SEQ_RR_EN
            // Granted 0 -> favour 1 next; granted 1 -> favour 0 next.
            r_favour <= out_grant[0];
`else
            // Fixed priority: requester 0 is always favoured.
            r_favour <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/rom_lut_sequencer.sv
// ---------------------------------------------------------------------------
// rom_lut_sequencer
// Serves burst reads from a synchronous ROM on behalf of two requesters.
// A request seen in IDLE latches the winner's start address and length,
// then the sequencer walks the ROM one address per cycle. The ROM returns
// data one cycle after the address, so valid/last are the READ-cycle
// qualifiers delayed by one register stage; the final word therefore
// emerges during the single DRAIN cycle.
// Configuration macro: ROM_LUT_SEQ_RR_EN (round-robin arbitration on ties,
// see rom_lut_seq_arb).
// Ports:
//   in_clk        clock, rising edge
//   in_rst        synchronous active-high reset
//   in_req        burst request per requester
//   in_addr       start address, slice i = requester i
//   in_len        burst length minus one, slice i = requester i
//   out_ack       one-cycle grant acknowledge per requester
//   out_rom_addr  registered ROM read address
//   in_rom_data   ROM read data (one cycle after address)
//   out_data      returned word (straight from in_rom_data)
//   out_valid     out_data valid for requester i (one-hot or zero)
//   out_last      final word of the burst
//   out_busy      high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module rom_lut_sequencer
    import rom_lut_seq_pkg::*;
#(
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int ROM_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic [1:0]                    in_req,
    input  logic [2*ROM_ADDR_WIDTH-1:0]   in_addr,
    input  logic [2*LEN_WIDTH-1:0]        in_len,
    output logic [1:0]                    out_ack,
    output logic [ROM_ADDR_WIDTH-1:0]     out_rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0]     in_rom_data,
    output logic [ROM_DATA_WIDTH-1:0]     out_data,
    output logic [1:0]                    out_valid,
    output logic                          out_last,
    output logic                          out_busy
);

    state_t                    r_state;
    state_t                    w_state_next;

    logic [ROM_ADDR_WIDTH-1:0] r_rom_addr;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [LEN_WIDTH-1:0]      r_count;
    logic [N_REQ-1:0]          r_owner;
    logic [N_REQ-1:0]          r_ack;
    logic [N_REQ-1:0]          r_valid;
    logic                      r_last;

    logic [ROM_ADDR_WIDTH-1:0] w_addr_slice [N_REQ];
    logic [LEN_WIDTH-1:0]      w_len_slice  [N_REQ];
    logic [ROM_ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]      w_sel_len;
    logic [N_REQ-1:0]          w_grant;
    logic                      w_start;
    logic                      w_final_addr;

    // Split the packed per-requester buses into arrays.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_addr_slice[gi] = in_addr[gi*ROM_ADDR_WIDTH +: ROM_ADDR_WIDTH];
            assign w_len_slice[gi]  = in_len[gi*LEN_WIDTH +: LEN_WIDTH];
        end
    endgenerate

    // Requests are only looked at while idle.
    assign w_start      = (r_state == ST_IDLE) && (|in_req);
    assign w_final_addr = (r_count == r_len);

    rom_lut_seq_arb u_arb (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_req    (in_req),
        .in_update (w_start),
        .out_grant (w_grant)
    );

    // One-hot grant selects the winner's address and length (AND-OR mux).
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | w_addr_slice[i];
                w_sel_len  = w_sel_len  | w_len_slice[i];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)      w_state_next = ST_READ;
            ST_READ:  if (w_final_addr) w_state_next = ST_DRAIN;
            ST_DRAIN:                   w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_owner    <= '0;
            r_ack      <= '0;
            r_valid    <= '0;
            r_last     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_start ? w_grant : '0;
            // The address issued this READ cycle returns data next cycle.
            r_valid <= (r_state == ST_READ) ? r_owner : '0;
            r_last  <= (r_state == ST_READ) && w_final_addr;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_rom_addr <= w_sel_addr;
                        r_len      <= w_sel_len;
                        r_owner    <= w_grant;
                        r_count    <= '0;
                    end
                end
                ST_READ: begin
                    // Address wraps naturally at the top of the ROM.
                    if (!w_final_addr) begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_count    <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_ack      = r_ack;
    assign out_rom_addr = r_rom_addr;
    assign out_data     = in_rom_data;
    assign out_valid    = r_valid;
    assign out_last     = r_last;
    assign out_busy     = (r_state != ST_IDLE);

endmodule
